// File: rtl/riscv_pkg.sv
// riscv_pkg: constants and types shared by the fetch/decode boundary.
//   XLEN, ILEN        - default pc and instruction widths
//   *_LSB             - bit positions of the standard RV fields inside an instruction
//   STOP_WORD_DEFAULT - instruction encoding that terminates fetch
//   ifid_entry_t      - one buffered {pc, instr} pair at the default widths
package riscv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    localparam logic [31:0] STOP_WORD_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_fifo.sv
// ifid_fifo: generic in-order storage with read/write pointers and an occupancy count.
//   clk, reset   - clock, asynchronous active-high reset (clears entries, pointers, count)
//   push, wdata  - write wdata at the tail (caller guarantees not full)
//   pop          - drop the head entry (caller guarantees not empty)
//   clear        - synchronous squash of all entries; overrides push and pop
//   rdata        - head entry (stale contents when count is 0)
//   count        - number of valid entries, 0..DEPTH
module ifid_fifo #(
    parameter int unsigned WIDTH = 96,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;

    // DEPTH is a power of two, so plain pointer overflow is the modulo-DEPTH wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

    always @(posedge clk) begin
        if (!reset && !clear) begin
            assert (!(push && count_q == FullCount));
            assert (!(pop && count_q == '0));
        end
    end

endmodule

// File: rtl/ifid_stage_buffer.sv
// ifid_stage_buffer: receiving end of the fetch-to-decode interface.
//   clk, reset                  - clock, asynchronous active-high reset
//   if_valid, if_pc, if_instr   - fetch offer; accepted when if_ready is high
//   if_ready                    - buffer can accept (registered-state only)
//   flush                       - squash all buffered entries and the stop state
//   id_ready                    - decode consumes the head entry
//   id_valid, id_pc, id_instr   - head entry (zero when id_valid is low)
//   id_opcode..id_funct7        - RV field slices of id_instr
//   id_stop                     - stop word seen and buffer drained
// Optional build macro IFID_PERF_EN adds saturating counters:
//   perf_stall_cycles - cycles with if_valid && !if_ready
//   perf_flush_count  - number of flush cycles
// Field slicing assumes ILEN is 32.
module ifid_stage_buffer #(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter int unsigned     ILEN      = riscv_pkg::ILEN,
    parameter int unsigned     DEPTH     = 2,
    parameter logic [ILEN-1:0] STOP_WORD = ILEN'(riscv_pkg::STOP_WORD_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [ILEN-1:0] if_instr,
    output logic            if_ready,
    input  logic            flush,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [ILEN-1:0] id_instr,
    output logic [6:0]      id_opcode,
    output logic [4:0]      id_rd,
    output logic [2:0]      id_funct3,
    output logic [4:0]      id_rs1,
    output logic [4:0]      id_rs2,
    output logic [6:0]      id_funct7,
    output logic            id_stop
`ifdef IFID_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_flush_count
`endif
);

    import riscv_pkg::*;

    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    entry_t          wr_entry;
    entry_t          head;
    logic [CntW-1:0] count;
    logic            halted_q;
    logic            full;
    logic            empty;
    logic            accept;
    logic            is_stop;
    logic            push;
    logic            pop;

    assign full  = (count == CntW'(DEPTH));
    assign empty = (count == '0);

    assign if_ready = !reset && !halted_q && !full;
    assign accept   = if_valid && if_ready;
    assign is_stop  = (if_instr == STOP_WORD);

    // The stop word is consumed by the halt flag rather than stored; flush beats everything.
    assign push = accept && !is_stop && !flush;
    assign pop  = id_valid && id_ready && !flush;

    assign wr_entry.pc    = if_pc;
    assign wr_entry.instr = if_instr;

    ifid_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (flush),
        .wdata (wr_entry),
        .rdata (head),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else if (flush) begin
            halted_q <= 1'b0;
        end else if (accept && is_stop) begin
            halted_q <= 1'b1;
        end
    end

    assign id_valid = !empty;
    assign id_stop  = halted_q && empty;

    always_comb begin
        id_pc    = '0;
        id_instr = '0;
        if (id_valid) begin
            id_pc    = head.pc;
            id_instr = head.instr;
        end
    end

    assign id_opcode = id_instr[OPCODE_LSB +: 7];
    assign id_rd     = id_instr[RD_LSB     +: 5];
    assign id_funct3 = id_instr[FUNCT3_LSB +: 3];
    assign id_rs1    = id_instr[RS1_LSB    +: 5];
    assign id_rs2    = id_instr[RS2_LSB    +: 5];
    assign id_funct7 = id_instr[FUNCT7_LSB +: 7];

`ifdef IFID_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (if_valid && !if_ready && perf_stall_q != '1) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (flush && perf_flush_q != '1) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: doc/ifid_stage_buffer.md
Name: ifid_stage_buffer

Overview:
- Receiving end of the fetch-to-decode interface: accepts {pc, instruction} pairs from the fetch stage, holds them in a small in-order buffer, and presents them to decode.
- Carries a valid/ready handshake on both sides.
- Pre-slices the standard RV64 fields.
- Detects the program-stop word and converts it into a sticky stop flag.
- Supports branch flush from execute.

Parameters:
XLEN, 64, program counter width
ILEN, 32, instruction width
DEPTH, 2, buffer entries (power of two, >= 2)
STOP_WORD, 32'h0000_0000, instruction encoding that terminates fetch

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
if_valid  in  1  fetch offers if_pc/if_instr this cycle
if_pc  in  XLEN  pc of offered instruction
if_instr  in  ILEN  offered instruction word
if_ready  out  1  buffer can accept (fetch must hold pc when low)
flush  in  1  squash all buffered entries (branch taken / mispredict)
id_ready  in  1  decode consumes head entry this cycle
id_valid  out  1  head entry valid
id_pc  out  XLEN  head pc
id_instr  out  ILEN  head instruction
id_opcode  out  7  id_instr[6:0]
id_rd  out  5  id_instr[11:7]
id_funct3  out  3  id_instr[14:12]
id_rs1  out  5  id_instr[19:15]
id_rs2  out  5  id_instr[24:20]
id_funct7  out  7  id_instr[31:25]
id_stop  out  1  stop seen and buffer drained

Behaviour:
- Reset (async, immediate): count=0, pointers=0, halted=0, all entries cleared. While reset is high, if_ready=0. Reset also forces id_valid=0, id_pc=0, id_instr=0, all field outputs 0, and id_stop=0. Reset mid-transfer drops everything.
- Push: if_valid && if_ready at a rising edge writes the entry at wr_ptr. wr_ptr wraps modulo DEPTH.
- Pop: id_valid && id_ready at a rising edge advances rd_ptr, which wraps modulo DEPTH.
- Latency: an accepted instruction appears on id_* the next cycle when the buffer was empty. No combinational path from if_* to id_*.
- if_ready = !reset && !halted && (count != DEPTH). It is derived from registered state only, with no dependency on id_ready.
- Full + pop in the same cycle: no push that cycle. if_ready reasserts the following cycle.
- Empty + push + id_ready in the same cycle: the push lands. Nothing is popped, because id_valid was 0.
- Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
- id_valid = (count != 0). Field outputs are combinational slices of the head entry. All of id_pc, id_instr and the field outputs read 0 when id_valid=0.
- Stop handling: an accepted if_instr == STOP_WORD is not enqueued. It sets halted=1, and if_ready drops the next cycle.
- id_stop = halted && (count == 0). It is registered-state derived and stays high until reset or flush.
- Flush: synchronous. It takes priority over a same-cycle push and pop; both are discarded. It clears count, pointers, halted and id_stop.
  - id_valid=0 the cycle after flush.
  - if_ready=1 the cycle after flush.
- count width is clog2(DEPTH)+1. Overflow and underflow are impossible by construction. Assertions must flag push when count==DEPTH and pop when count==0.

Optional Feature:
IFID_PERF_EN defined:
- Adds output perf_stall_cycles (32 bits), which increments each cycle with if_valid && !if_ready.
- Adds output perf_flush_count (32 bits), which increments on each flush.
- Both counters saturate at all-ones and reset to 0.

IFID_PERF_EN undefined: the counters and their ports are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN and ILEN constants.
  - Field position constants (OPCODE_LSB etc.).
  - STOP_WORD default.
  - Typedef ifid_entry_t {pc, instr}.
- One natural sub-module: ifid_fifo. It is generic storage with pointers and count, push/pop/clear, and is parameterized by entry width and DEPTH.
- The top level adds stop detection, field slicing and perf counters.

Test Plan:
1. Reset release, then push pc=0x0 instr=0x00500093 with id_ready=1 → next cycle id_valid=1, id_opcode=0x13, id_rd=1, id_rs1=0. It pops the cycle after, leaving id_valid=0.
2. id_ready=0; push pc=0x0, 0x4, 0x8 back-to-back → the first two are accepted and if_ready=0 after the second. 0x8 is held by fetch and accepted one cycle after id_ready rises. Output order is 0x0, 0x4, 0x8.
3. Two entries buffered, flush asserted together with if_valid (pc=0x40) → next cycle count=0, id_valid=0, if_ready=1. 0x40 is not enqueued.
4. Push 0x00A00113, then STOP_WORD at pc=0x4 → if_ready=0 from the next cycle. id_stop=0 while 0x00A00113 is pending, and id_stop=1 the cycle after it pops.
5. Buffer half full with id_ready=1 and continuous if_valid for 8 cycles (pc 0x0..0x1C) → one push and one pop per cycle, all 8 delivered in order. This checks pointer wrap.
6. Assert reset asynchronously mid-cycle with 2 entries held → id_valid, if_ready, id_stop and id_pc go to 0 immediately, before the next clock edge.
